// File: rtl/flexbex_ibex_imem_arbiter.sv
// flexbex_ibex_imem_arbiter: shares one instruction-memory port between prefetch (0) and loader/debug (1).
// Define IMEM_ARB_RR_EN for round-robin arbitration instead of fixed priority.
module flexbex_ibex_imem_arbiter #(
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_req_i,
   input  logic [31:0] m0_addr_i,
   output logic        m0_gnt_o,
   output logic        m0_rvalid_o,
   input  logic        m1_req_i,
   input  logic [31:0] m1_addr_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_be_i,
   input  logic [31:0] m1_wdata_i,
   output logic        m1_gnt_o,
   output logic        m1_rvalid_o,
   output logic [31:0] rdata_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        busy_o,
   output logic        err_o
);
   localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [PW-1:0] LAST = PW'(MAX_OUTSTANDING - 1);
   localparam logic [2:0] MAXC = 3'(MAX_OUTSTANDING);

   logic [MAX_OUTSTANDING-1:0] ids_q, ids_d;
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [2:0] cnt_q, cnt_d;
   logic lock_q, lock_d, sel_q, sel_d;
   logic sel, prio, can_issue, push, pop, empty, head;

`ifdef IMEM_ARB_RR_EN
   // rr_q names the port that wins the next tie
   logic rr_q, rr_d;
   assign prio = rr_q;
   assign rr_d = push ? ~sel : rr_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rr_q <= 1'b0;
      else rr_q <= rr_d;
`else
   assign prio = 1'b0;
`endif

   assign empty     = cnt_q == 3'd0;
   assign head      = ids_q[rd_q];
   assign can_issue = (cnt_q < MAXC) | mem_rvalid_i;
   assign sel       = lock_q ? sel_q : (m0_req_i & m1_req_i ? prio : m1_req_i);

   assign mem_req_o   = can_issue & (sel ? m1_req_i : m0_req_i);
   assign mem_addr_o  = mem_req_o ? (sel ? m1_addr_i : m0_addr_i) : 32'h0;
   assign mem_we_o    = mem_req_o & sel & m1_we_i;
   assign mem_be_o    = mem_req_o ? (sel ? m1_be_i : 4'hF) : 4'h0;
   assign mem_wdata_o = mem_req_o & sel ? m1_wdata_i : 32'h0;

   assign push = mem_req_o & mem_gnt_i;
   assign pop  = mem_rvalid_i & ~empty;

   assign m0_gnt_o    = push & ~sel;
   assign m1_gnt_o    = push & sel;
   assign m0_rvalid_o = pop & ~head;
   assign m1_rvalid_o = pop & head;
   assign rdata_o     = mem_rdata_i;
   assign busy_o      = ~empty | mem_req_o;
   assign err_o       = mem_rvalid_i & empty;

   always_comb begin
      ids_d = ids_q;
      if (push) ids_d[wr_q] = sel;
      wr_d   = push ? (wr_q == LAST ? '0 : wr_q + 1'b1) : wr_q;
      rd_d   = pop ? (rd_q == LAST ? '0 : rd_q + 1'b1) : rd_q;
      cnt_d  = push & ~pop ? cnt_q + 3'd1 : (pop & ~push ? cnt_q - 3'd1 : cnt_q);
      lock_d = mem_req_o & ~mem_gnt_i;
      sel_d  = sel;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ids_q  <= '0;
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= 3'd0;
         lock_q <= 1'b0;
         sel_q  <= 1'b0;
      end else begin
         ids_q  <= ids_d;
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         cnt_q  <= cnt_d;
         lock_q <= lock_d;
         sel_q  <= sel_d;
      end
endmodule

// File: tb/tb_flexbex_ibex_imem_arbiter.sv
// tb_flexbex_ibex_imem_arbiter: vector table plus ID scoreboard for the instruction-memory arbiter.
module tb_flexbex_ibex_imem_arbiter;
   logic clk = 1'b0, rst_n = 1'b0;
   logic m0_req = 0, m1_req = 0, m1_we = 0, gnt = 0, rv = 0;
   logic [31:0] m0_addr = 0, m1_addr = 0, m1_wdata = 0, rdata = 0;
   logic [3:0] m1_be = 0;
   logic m0_gnt, m0_rv, m1_gnt, m1_rv, mem_req, mem_we, busy, err;
   logic [31:0] rdata_o, mem_addr, mem_wdata;
   logic [3:0] mem_be;
   int tests = 0, fails = 0;
   int sb[$];

   typedef struct {
      logic r0; logic [31:0] a0; logic r1; logic [31:0] a1; logic we1; logic [3:0] be1; logic [31:0] wd1;
      logic gnt; logic rv;
      logic eg0, eg1, ereq; logic [31:0] eaddr; logic ewe; logic [3:0] ebe; logic [31:0] ewd; logic ebusy, eerr;
   } vec_t;
   vec_t vecs[$];

   always #5 clk = ~clk;

   flexbex_ibex_imem_arbiter #(.MAX_OUTSTANDING(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rv),
      .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_wdata_i(m1_wdata),
      .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rv), .rdata_o(rdata_o),
      .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be),
      .mem_wdata_o(mem_wdata), .mem_gnt_i(gnt), .mem_rvalid_i(rv), .mem_rdata_i(rdata),
      .busy_o(busy), .err_o(err)
   );

   function automatic vec_t v(logic r0, logic [31:0] a0, logic r1, logic [31:0] a1, logic we1,
                              logic [3:0] be1, logic [31:0] wd1, logic g, logic r,
                              logic eg0, logic eg1, logic ereq, logic [31:0] eaddr, logic ewe,
                              logic [3:0] ebe, logic [31:0] ewd, logic ebusy, logic eerr);
      vec_t x;
      x.r0 = r0; x.a0 = a0; x.r1 = r1; x.a1 = a1; x.we1 = we1; x.be1 = be1; x.wd1 = wd1;
      x.gnt = g; x.rv = r; x.eg0 = eg0; x.eg1 = eg1; x.ereq = ereq; x.eaddr = eaddr;
      x.ewe = ewe; x.ebe = ebe; x.ewd = ewd; x.ebusy = ebusy; x.eerr = eerr;
      return x;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      m0_req = 0; m1_req = 0; m0_addr = 0; m1_addr = 0; m1_we = 0; m1_be = 0; m1_wdata = 0;
      gnt = 0; rv = 0; rdata = 0;
   endtask

   initial begin
      // vector table: each row is one clock cycle; state carries between rows
      vecs.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
      vecs.push_back(v(1,'h100,0,0,0,0,0,1,0, 1,0,1,'h100,0,'hF,0,1,0));
      vecs.push_back(v(1,'h104,0,0,0,0,0,1,1, 1,0,1,'h104,0,'hF,0,1,0));
      vecs.push_back(v(0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,1,0));
      vecs.push_back(v(1,'h10,1,'h20,1,'h3,'hDEAD,1,0, 1,0,1,'h10,0,'hF,0,1,0));
      vecs.push_back(v(1,'h14,1,'h20,1,'h3,'hDEAD,1,1, 1,0,1,'h14,0,'hF,0,1,0));
      vecs.push_back(v(0,0,1,'h20,1,'h3,'hDEAD,1,1, 0,1,1,'h20,1,'h3,'hDEAD,1,0));
      vecs.push_back(v(0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,1,0));
      vecs.push_back(v(0,0,1,'h200,0,'hF,0,0,0, 0,0,1,'h200,0,'hF,0,1,0));
      vecs.push_back(v(0,0,1,'h300,0,'hF,0,0,0, 0,0,1,'h300,0,'hF,0,1,0));
      vecs.push_back(v(1,'h400,1,'h300,0,'hF,0,0,0, 0,0,1,'h300,0,'hF,0,1,0));
      vecs.push_back(v(1,'h400,1,'h300,0,'hF,0,1,0, 0,1,1,'h300,0,'hF,0,1,0));
      vecs.push_back(v(1,'h400,0,0,0,0,0,1,1, 1,0,1,'h400,0,'hF,0,1,0));
      vecs.push_back(v(0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,1,0));
      vecs.push_back(v(0,0,1,'h500,1,'h5,'h55,1,0, 0,1,1,'h500,1,'h5,'h55,1,0));
      vecs.push_back(v(1,'h600,0,0,0,0,0,1,0, 1,0,1,'h600,0,'hF,0,1,0));
      vecs.push_back(v(1,'h600,1,'h500,1,'h5,'h55,1,0, 0,0,0,0,0,0,0,1,0));
      vecs.push_back(v(1,'h600,1,'h500,1,'h5,'h55,1,1, 1,0,1,'h600,0,'hF,0,1,0));
      vecs.push_back(v(0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,1,0));
      vecs.push_back(v(0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,1,0));
      vecs.push_back(v(0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,0,1));
      vecs.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
      vecs.push_back(v(0,0,1,'h700,0,'hF,0,0,0, 0,0,1,'h700,0,'hF,0,1,0));
      vecs.push_back(v(1,'h800,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
      vecs.push_back(v(1,'h800,0,0,0,0,0,1,0, 1,0,1,'h800,0,'hF,0,1,0));
      vecs.push_back(v(0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,1,0));

      idle();
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      for (int i = 0; i < vecs.size(); i++) begin
         vec_t e;
         int exp_id;
         e = vecs[i];
         @(posedge clk);
         #1;
         m0_req = e.r0; m0_addr = e.a0; m1_req = e.r1; m1_addr = e.a1; m1_we = e.we1;
         m1_be = e.be1; m1_wdata = e.wd1; gnt = e.gnt; rv = e.rv;
         rdata = 32'hC0DE0000 + 32'(i);
         #3;
         chk($sformatf("v%0d gnt0", i), 32'(m0_gnt), 32'(e.eg0));
         chk($sformatf("v%0d gnt1", i), 32'(m1_gnt), 32'(e.eg1));
         chk($sformatf("v%0d req", i), 32'(mem_req), 32'(e.ereq));
         chk($sformatf("v%0d addr", i), mem_addr, e.eaddr);
         chk($sformatf("v%0d we", i), 32'(mem_we), 32'(e.ewe));
         chk($sformatf("v%0d be", i), 32'(mem_be), 32'(e.ebe));
         chk($sformatf("v%0d wdata", i), mem_wdata, e.ewd);
         chk($sformatf("v%0d busy", i), 32'(busy), 32'(e.ebusy));
         chk($sformatf("v%0d err", i), 32'(err), 32'(e.eerr));
         chk($sformatf("v%0d rdata", i), rdata_o, 32'hC0DE0000 + 32'(i));
         exp_id = -1;
         if (e.rv && sb.size() > 0) exp_id = sb.pop_front();
         chk($sformatf("v%0d rvalid0", i), 32'(m0_rv), 32'(exp_id == 0));
         chk($sformatf("v%0d rvalid1", i), 32'(m1_rv), 32'(exp_id == 1));
         if (e.eg0) sb.push_back(0);
         if (e.eg1) sb.push_back(1);
      end
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard: %0d responses left, expected 0", sb.size());
      end

      // reset with two reads outstanding, then a stray response
      @(posedge clk);
      #1 idle(); m0_req = 1; m0_addr = 'h900; gnt = 1;
      #3 chk("rst g1", 32'(m0_gnt), 1);
      @(posedge clk);
      #1 m0_addr = 'h904;
      #3 chk("rst g2", 32'(m0_gnt), 1);
      @(posedge clk);
      #1 idle();
      #3 chk("rst busy pre", 32'(busy), 1);
      #1 rst_n = 0;
      #1 chk("rst busy post", 32'(busy), 0);
      chk("rst req", 32'(mem_req), 0);
      @(posedge clk);
      #1 rst_n = 1;
      @(posedge clk);
      #1 rv = 1;
      #3 chk("stray err", 32'(err), 1);
      chk("stray rv0", 32'(m0_rv), 0);
      chk("stray rv1", 32'(m1_rv), 0);
      @(posedge clk);
      #1 rv = 0;
      #3 chk("stray err end", 32'(err), 0);
      chk("stray busy", 32'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
